dmem_port_arbiter: RTL and testbench

- Arbiter and sequencer for a single-ported unified memory that is shared between the IF stage (instruction reads) and the MEM stage (data loads and stores driven by MemRead/MemWrite, ALUResult, read_data2).
- Issues one command at a time to the memory and waits for the memory's ready pulse.
- Returns data with a one-cycle ack to the requester that owns the access.
- Produces stall signals for the pipeline hazard logic.

---
 rtl/dmem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Arbiter/sequencer sharing one single-ported memory between instruction fetch and data access.
// One command in flight; ready-or-timeout completion; one-cycle ack to the owning requester.
module dmem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic              bus_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready
);

  // state | meaning
  // IDLE  | sample requests, pick owner, latch command
  // ISSUE | ram_en strobe for one cycle
  // WAIT  | wait for ram_ready or timeout
  // ACK   | owner's ack (and bus_err) visible; no sampling
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  state_t     state;
  owner_t     owner;
  logic [3:0] starveCnt;
  logic [7:0] timeoutCnt;
  logic       memReq;
  logic       grantMem;

  assign memReq   = mem_read | mem_write;
  assign grantMem = memReq & ~(if_req & (starveCnt == STARVE_LIM));

  assign if_stall  = if_req & ~if_ack;
  assign mem_stall = memReq & ~mem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      starveCnt  <= '0;
      timeoutCnt <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      if_ack     <= 1'b0;
      mem_ack    <= 1'b0;
      bus_err    <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      ram_en  <= 1'b0;
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (memReq || if_req) begin
            state  <= ISSUE;
            ram_en <= 1'b1;
            if (grantMem) begin
              owner     <= OWN_MEM;
              ram_addr  <= mem_addr;
              ram_wdata <= mem_wdata;
              ram_we    <= mem_write;
              if (!if_req)
                starveCnt <= '0;
              else if (starveCnt != STARVE_LIM)
                starveCnt <= starveCnt + 4'd1;
            end else begin
              owner     <= OWN_IF;
              ram_addr  <= if_addr;
              ram_we    <= 1'b0;
              starveCnt <= '0;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          timeoutCnt <= timeoutCnt + 8'd1;
          if (ram_ready) begin
            state <= ACK;
            if (owner == OWN_MEM) begin
              mem_ack <= 1'b1;
              if (!ram_we) mem_rdata <= ram_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= ram_rdata;
            end
          end else if (timeoutCnt == TO_LAST) begin
            // Abort: owner sees zero data flagged with bus_err.
            state   <= ACK;
            bus_err <= 1'b1;
            if (owner == OWN_MEM) begin
              mem_ack   <= 1'b1;
              mem_rdata <= '0;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= '0;
            end
          end
        end
        ACK: begin
          state      <= IDLE;
          owner      <= OWN_NONE;
          timeoutCnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: directed stimulus pushes expected acks,
// a monitor pops and compares whenever an ack appears.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_read, mem_write;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic        if_ack, mem_ack, if_stall, mem_stall, bus_err;
  logic [31:0] if_rdata, mem_rdata;
  logic        ram_en, ram_we, ram_ready;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  dmem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_MAX(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_stall(mem_stall), .bus_err(bus_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        isMem;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails  = 0;

  // memory model controls
  int          readyDelay = 1;   // 0: never respond
  logic [31:0] memRdata = '0;
  int          strayReqs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pushExp(input logic isMem, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.isMem = isMem; e.rdata = rdata; e.err = err;
    expQ.push_back(e);
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_ram_en"},    64'(ram_en),    64'd0);
    check({tag, "_ram_we"},    64'(ram_we),    64'd0);
    check({tag, "_ram_addr"},  64'(ram_addr),  64'd0);
    check({tag, "_ram_wdata"}, 64'(ram_wdata), 64'd0);
    check({tag, "_acks_err"},  64'({if_ack, mem_ack, bus_err}), 64'd0);
    check({tag, "_if_rdata"},  64'(if_rdata),  64'd0);
    check({tag, "_mem_rdata"}, 64'(mem_rdata), 64'd0);
  endtask

  task automatic waitAck(input string name, input logic isMem, input int maxC);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < maxC && !seen; i++) begin
      tick();
      if (isMem ? mem_ack : if_ack) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  // Memory responder: pulses ram_ready readyDelay cycles after the ram_en cycle.
  initial begin
    int pend;
    int strayDone;
    pend = 0; strayDone = 0;
    ram_ready = 1'b0;
    ram_rdata = '0;
    forever begin
      tick();
      ram_ready = 1'b0;
      if (strayReqs != strayDone) begin
        strayDone = strayReqs;
        ram_ready = 1'b1;
        ram_rdata = 32'hBAD0BAD0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          ram_ready = 1'b1;
          ram_rdata = memRdata;
        end
      end
      if (ram_en && !rst && readyDelay > 0) pend = readyDelay;
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      tick();
      if (if_ack && mem_ack) check("one_ack", 64'd2, 64'd1);
      if (if_ack || mem_ack) begin
        if (expQ.size() == 0) begin
          check("unexpected_ack", {62'd0, if_ack, mem_ack}, 64'd0);
        end else begin
          e = expQ.pop_front();
          check("ack_port", 64'(mem_ack), 64'(e.isMem));
          check("ack_rdata", 64'(mem_ack ? mem_rdata : if_rdata), 64'(e.rdata));
          check("ack_bus_err", 64'(bus_err), 64'(e.err));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic early;
    rst = 1'b1;
    if_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    tick(); tick();
    checkReset("rst");
    if_req = 1'b1;
    #1 check("stall_in_reset", 64'(if_stall), 64'd1);
    if_req = 1'b0;
    tick();
    rst = 1'b0;

    // 1: single load, minimum latency
    tick();
    mem_read = 1'b1; mem_addr = 32'h40; memRdata = 32'hDEADBEEF; readyDelay = 1;
    pushExp(1'b1, 32'hDEADBEEF, 1'b0);
    #1 check("t1_stall_T", 64'(mem_stall), 64'd1);
    tick();
    check("t1_ram_en", 64'(ram_en), 64'd1);
    check("t1_ram_we", 64'(ram_we), 64'd0);
    check("t1_ram_addr", 64'(ram_addr), 64'h40);
    check("t1_stall_T1", 64'(mem_stall), 64'd1);
    tick();
    check("t1_en_one_cycle", 64'(ram_en), 64'd0);
    check("t1_stall_T2", 64'(mem_stall), 64'd1);
    tick();
    check("t1_ack_T3", 64'(mem_ack), 64'd1);
    check("t1_stall_T3", 64'(mem_stall), 64'd0);
    mem_read = 1'b0;

    // 2: store and fetch together; store first
    tick();
    mem_write = 1'b1; mem_addr = 32'h80; mem_wdata = 32'h12345678;
    if_req = 1'b1; if_addr = 32'h100; memRdata = 32'hCAFEF00D;
    pushExp(1'b1, 32'hDEADBEEF, 1'b0);
    pushExp(1'b0, 32'hCAFEF00D, 1'b0);
    tick();
    check("t2_st_en", 64'(ram_en), 64'd1);
    check("t2_st_we", 64'(ram_we), 64'd1);
    check("t2_st_addr", 64'(ram_addr), 64'h80);
    check("t2_st_wdata", 64'(ram_wdata), 64'h12345678);
    check("t2_if_stall1", 64'(if_stall), 64'd1);
    tick();
    tick();
    check("t2_st_ack", 64'(mem_ack), 64'd1);
    check("t2_if_stall_ack", 64'(if_stall), 64'd1);
    mem_write = 1'b0;
    tick();
    check("t2_idle_no_en", 64'(ram_en), 64'd0);
    tick();
    check("t2_if_en", 64'(ram_en), 64'd1);
    check("t2_if_we", 64'(ram_we), 64'd0);
    check("t2_if_addr", 64'(ram_addr), 64'h100);
    tick();
    check("t2_if_stall_wait", 64'(if_stall), 64'd1);
    tick();
    check("t2_if_ack", 64'(if_ack), 64'd1);
    check("t2_if_stall_done", 64'(if_stall), 64'd0);
    if_req = 1'b0;

    // 3: starvation limit: MEM x4, IF, MEM
    tick();
    if_req = 1'b1; if_addr = 32'h300; mem_read = 1'b1; mem_addr = 32'h200;
    memRdata = 32'h00001111;
    for (int i = 0; i < 6; i++) pushExp(i != 4, 32'h00001111, 1'b0);
    for (int i = 0; i < 6; i++) begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        tick();
        if (if_ack || mem_ack) seen = 1'b1;
      end
      check("t3_grant_done", 64'(seen), 64'd1);
    end
    if_req = 1'b0; mem_read = 1'b0;

    // 4: timeout after 16 WAIT cycles, then stray ready ignored
    tick();
    mem_read = 1'b1; mem_addr = 32'h44; readyDelay = 0;
    pushExp(1'b1, 32'h0, 1'b1);
    tick();
    check("t4_ram_en", 64'(ram_en), 64'd1);
    early = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (mem_ack || bus_err) early = 1'b1;
    end
    check("t4_no_early_ack", 64'(early), 64'd0);
    tick();
    check("t4_ack_err", 64'({mem_ack, bus_err}), 64'b11);
    check("t4_rdata_zero", 64'(mem_rdata), 64'd0);
    mem_read = 1'b0;
    tick();
    strayReqs++;
    repeat (6) tick();

    // 5: reset during WAIT aborts access; late ready ignored
    mem_read = 1'b1; mem_addr = 32'h48; readyDelay = 5; memRdata = 32'h77777777;
    tick();
    tick();
    check("t5_in_wait", 64'(ram_addr), 64'h48);
    rst = 1'b1;
    tick();
    checkReset("t5");
    rst = 1'b0; mem_read = 1'b0;
    repeat (8) tick();

    // 6: read+write together is a store; rdata unchanged
    mem_read = 1'b1; mem_write = 1'b1; mem_addr = 32'h4C; mem_wdata = 32'hA5A5A5A5;
    memRdata = 32'hFFFF0000; readyDelay = 2;
    pushExp(1'b1, 32'h0, 1'b0);
    tick();
    check("t6_we", 64'(ram_we), 64'd1);
    check("t6_wdata", 64'(ram_wdata), 64'hA5A5A5A5);
    waitAck("t6_ack", 1'b1, 8);
    mem_read = 1'b0; mem_write = 1'b0;
    tick();
    check("t6_rdata_kept", 64'(mem_rdata), 64'd0);

    repeat (4) tick();
    check("queue_empty", 64'(expQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
